// File: rtl/fft_pkg.sv
// Shared FFT datapath types and constants.
// Holds the complex sample and twiddle structs (at the default 16-bit widths)
// and the twiddle mode encoding used by the multiplier.
package fft_pkg;

   localparam int FFT_DATA_WIDTH = 16;
   localparam int FFT_COEF_WIDTH = 16;

   typedef struct packed {
      logic signed [FFT_DATA_WIDTH-1:0] re;
      logic signed [FFT_DATA_WIDTH-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [FFT_COEF_WIDTH-1:0] cos;
      logic signed [FFT_COEF_WIDTH-1:0] sin;
   } twiddle_t;

   // Forward multiplies by (cos - j*sin); inverse uses the conjugate (cos + j*sin).
   localparam logic TW_FWD = 1'b0;
   localparam logic TW_INV = 1'b1;

   function automatic logic isInverse(input logic mode);
      return (mode == TW_INV);
   endfunction

endpackage

// File: rtl/tw_round_sat.sv
// Combinational rescaler for one twiddle product component.
// Adds half an LSB of the output scale, shifts right arithmetically by
// FRAC_BITS and narrows to OUT_WIDTH. Macro TWIDDLE_MUL_SAT_EN selects
// clamping with a sat flag; without it the value wraps and sat_o is 0.
module tw_round_sat #(
   parameter int IN_WIDTH  = 33,
   parameter int OUT_WIDTH = 16,
   parameter int FRAC_BITS = 15
) (
   input  logic signed [IN_WIDTH-1:0]  val_i,
   output logic signed [OUT_WIDTH-1:0] val_o,
   output logic                        sat_o
);

   // One extra bit so that adding the rounding constant can never overflow.
   localparam int RW = IN_WIDTH + 1;
   localparam logic signed [RW-1:0] ONE   = RW'(1);
   localparam logic signed [RW-1:0] HALF  = ONE <<< (FRAC_BITS - 1);
   localparam logic signed [RW-1:0] MAX_V = (ONE <<< (OUT_WIDTH - 1)) - ONE;
   localparam logic signed [RW-1:0] MIN_V = -(ONE <<< (OUT_WIDTH - 1));

   logic signed [RW-1:0] rounded;
   logic signed [RW-1:0] scaled;

   assign rounded = RW'(val_i) + HALF;
   assign scaled  = rounded >>> FRAC_BITS;

`ifdef TWIDDLE_MUL_SAT_EN
   // Clamp to the nearest representable bound and flag the clip.
   always_comb begin
      val_o = OUT_WIDTH'(scaled);
      sat_o = 1'b0;
      if (scaled > MAX_V) begin
         val_o = OUT_WIDTH'(MAX_V);
         sat_o = 1'b1;
      end else if (scaled < MIN_V) begin
         val_o = OUT_WIDTH'(MIN_V);
         sat_o = 1'b1;
      end
   end
`else
   assign val_o = OUT_WIDTH'(scaled);
   assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/twiddle_mul_pipe.sv
// Three-stage signed complex twiddle multiplier with valid/ready flow control.
// S1 registers the four partial products, S2 the signed sums, S3 the rounded
// and narrowed result. Each stage has its own valid so bubbles collapse under
// backpressure. Optional saturation is selected by TWIDDLE_MUL_SAT_EN inside
// tw_round_sat; otherwise results wrap and out_sat_o stays 0.
module twiddle_mul_pipe
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int FRAC_BITS  = COEF_WIDTH - 1,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic                         inv_i,
   input  logic signed [DATA_WIDTH-1:0] data_re_i,
   input  logic signed [DATA_WIDTH-1:0] data_im_i,
   input  logic signed [COEF_WIDTH-1:0] cos_theta_i,
   input  logic signed [COEF_WIDTH-1:0] sin_theta_i,
   input  logic [TAG_WIDTH-1:0]         in_tag_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic signed [DATA_WIDTH-1:0] out_re_o,
   output logic signed [DATA_WIDTH-1:0] out_im_o,
   output logic                         out_sat_o,
   output logic [TAG_WIDTH-1:0]         out_tag_o
);

   localparam int PW = DATA_WIDTH + COEF_WIDTH;
   localparam int SW = PW + 1;

   logic s1Valid_q, s2Valid_q, s3Valid_q;
   logic s1Adv, s2Adv, s3Adv;

   logic signed [PW-1:0] prodRc_d, prodIs_d, prodIc_d, prodRs_d;
   logic signed [PW-1:0] prodRc_q, prodIs_q, prodIc_q, prodRs_q;
   logic                 s1Inv_q;
   logic [TAG_WIDTH-1:0] s1Tag_q;

   logic signed [SW-1:0] sumRe_d, sumIm_d;
   logic signed [SW-1:0] sumRe_q, sumIm_q;
   logic [TAG_WIDTH-1:0] s2Tag_q;

   logic signed [DATA_WIDTH-1:0] roundRe, roundIm;
   logic                         satRe, satIm;
   logic signed [DATA_WIDTH-1:0] outRe_q, outIm_q;
   logic                         outSat_q;
   logic [TAG_WIDTH-1:0]         s3Tag_q;

   // A stage moves when it is empty or its successor moves; S3 moves on out_ready.
   always_comb begin
      s3Adv = !s3Valid_q || out_ready_i;
      s2Adv = !s2Valid_q || s3Adv;
      s1Adv = !s1Valid_q || s2Adv;
   end

   assign in_ready_o = s1Adv;

   // Four partial products of the incoming sample and twiddle.
   always_comb begin
      prodRc_d = PW'(data_re_i) * PW'(cos_theta_i);
      prodIs_d = PW'(data_im_i) * PW'(sin_theta_i);
      prodIc_d = PW'(data_im_i) * PW'(cos_theta_i);
      prodRs_d = PW'(data_re_i) * PW'(sin_theta_i);
   end

   // S1 captures products, mode and tag of an accepted beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1Valid_q <= 1'b0;
         prodRc_q  <= '0;
         prodIs_q  <= '0;
         prodIc_q  <= '0;
         prodRs_q  <= '0;
         s1Inv_q   <= TW_FWD;
         s1Tag_q   <= '0;
      end else if (s1Adv) begin
         s1Valid_q <= in_valid_i;
         if (in_valid_i) begin
            prodRc_q <= prodRc_d;
            prodIs_q <= prodIs_d;
            prodIc_q <= prodIc_d;
            prodRs_q <= prodRs_d;
            s1Inv_q  <= inv_i;
            s1Tag_q  <= in_tag_i;
         end
      end
   end

   // Combine products; the inverse mode flips the sign of the sin terms.
   always_comb begin
      sumRe_d = SW'(prodRc_q) + SW'(prodIs_q);
      sumIm_d = SW'(prodIc_q) - SW'(prodRs_q);
      if (isInverse(s1Inv_q)) begin
         sumRe_d = SW'(prodRc_q) - SW'(prodIs_q);
         sumIm_d = SW'(prodIc_q) + SW'(prodRs_q);
      end
   end

   // S2 holds the full-precision sums, one bit wider than the products.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2Valid_q <= 1'b0;
         sumRe_q   <= '0;
         sumIm_q   <= '0;
         s2Tag_q   <= '0;
      end else if (s2Adv) begin
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            sumRe_q <= sumRe_d;
            sumIm_q <= sumIm_d;
            s2Tag_q <= s1Tag_q;
         end
      end
   end

   tw_round_sat #(
      .IN_WIDTH (SW),
      .OUT_WIDTH(DATA_WIDTH),
      .FRAC_BITS(FRAC_BITS)
   ) uRoundRe (
      .val_i(sumRe_q),
      .val_o(roundRe),
      .sat_o(satRe)
   );

   tw_round_sat #(
      .IN_WIDTH (SW),
      .OUT_WIDTH(DATA_WIDTH),
      .FRAC_BITS(FRAC_BITS)
   ) uRoundIm (
      .val_i(sumIm_q),
      .val_o(roundIm),
      .sat_o(satIm)
   );

   // S3 is the output register; it only changes on advance so stalls hold it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s3Valid_q <= 1'b0;
         outRe_q   <= '0;
         outIm_q   <= '0;
         outSat_q  <= 1'b0;
         s3Tag_q   <= '0;
      end else if (s3Adv) begin
         s3Valid_q <= s2Valid_q;
         if (s2Valid_q) begin
            outRe_q  <= roundRe;
            outIm_q  <= roundIm;
            outSat_q <= satRe | satIm;
            s3Tag_q  <= s2Tag_q;
         end
      end
   end

   assign out_valid_o = s3Valid_q;
   assign out_re_o    = outRe_q;
   assign out_im_o    = outIm_q;
   assign out_sat_o   = outSat_q;
   assign out_tag_o   = s3Tag_q;

endmodule
